// File: rtl/led_fader.sv
// ----------------------------------------------------------------------------
// led_fader
// Per-LED PWM fade stage. Each pattern bit is an on/off brightness target; a
// per-channel brightness register ramps toward that target by one step per
// fade tick. Each pin is driven by comparing the channel duty against a shared
// free-running PWM counter, so pattern changes cross-fade instead of snapping.
//
// Optional feature macro: LED_FADER_GAMMA_EN
//   When defined, duty = (b*b) >> PWM_BITS through a registered stage, so leds
//   lag brightness by two cycles. When undefined, duty = b and leds lag it by
//   one cycle.
//
// Parameters
//   NLEDS      number of LED channels
//   PWM_BITS   width of the PWM counter and brightness registers
//   STEP_LOG2  fade tick period is 2^STEP_LOG2 clk cycles (1..24)
//
// Ports
//   clk           in   single clock, all state on posedge
//   resetn        in   synchronous active-low reset
//   pattern       in   [NLEDS]      target pattern, bit i=1 -> LED i full on
//   leds          out  [NLEDS]      registered PWM pin outputs
//   busy          out  1            registered, high while any channel fades
//   o_dbg_state   out  [2*NLEDS]    per-channel FSM state, channel i at [2i+:2]
//   o_dbg_bright  out  [NLEDS*PWM_BITS] per-channel brightness, channel i at
//                                   [i*PWM_BITS +: PWM_BITS]
//
// Handshake: none. pattern is a level input that may change on any cycle and
// is sampled unconditionally every clock; outputs are valid every cycle.
// ----------------------------------------------------------------------------
module led_fader #(
  parameter int NLEDS     = 8,
  parameter int PWM_BITS  = 8,
  parameter int STEP_LOG2 = 14
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NLEDS-1:0]          pattern,
  output logic [NLEDS-1:0]          leds,
  output logic                      busy,
  output logic [2*NLEDS-1:0]        o_dbg_state,
  output logic [NLEDS*PWM_BITS-1:0] o_dbg_bright
);

  localparam logic [PWM_BITS-1:0] BMAX = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } chan_state_t;

  logic [NLEDS-1:0]     r_pattern_q;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [STEP_LOG2-1:0] r_pre_cnt;
  chan_state_t          r_state      [NLEDS];
  chan_state_t          w_state_nxt  [NLEDS];
  logic [PWM_BITS-1:0]  r_bright     [NLEDS];
  logic [PWM_BITS-1:0]  w_bright_nxt [NLEDS];
  logic [PWM_BITS-1:0]  w_duty       [NLEDS];
  logic [NLEDS-1:0]     w_moving;
  logic                 w_tick;

  assign w_tick = &r_pre_cnt;

  // Input register, PWM counter and fade prescaler; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pattern_q <= '0;
      r_pwm_cnt   <= '0;
      r_pre_cnt   <= '0;
    end else begin
      r_pattern_q <= pattern;
      r_pwm_cnt   <= r_pwm_cnt + ONE;
      r_pre_cnt   <= r_pre_cnt + STEP_LOG2'(1);
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NLEDS; i++) begin
        r_state[i]  <= ST_OFF;
        r_bright[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NLEDS; i++) begin
        r_state[i]  <= w_state_nxt[i];
        r_bright[i] <= w_bright_nxt[i];
      end
    end
  end

  // Channel next-state. A reversal takes priority over a tick so brightness
  // holds on the reversal cycle. A reversal can leave a channel moving while
  // already at the endpoint it is heading to (e.g. a 1-cycle pattern pulse);
  // such a channel settles on the next cycle without stepping, so b never wraps.
  always_comb begin
    for (int i = 0; i < NLEDS; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_bright_nxt[i] = r_bright[i];
      case (r_state[i])
        ST_OFF: begin
          if (r_pattern_q[i]) w_state_nxt[i] = ST_RISING;
        end
        ST_RISING: begin
          if (!r_pattern_q[i]) begin
            w_state_nxt[i] = ST_FALLING;
          end else if (r_bright[i] == BMAX) begin
            w_state_nxt[i] = ST_ON;
          end else if (w_tick) begin
            w_bright_nxt[i] = r_bright[i] + ONE;
            if (r_bright[i] == BMAX - ONE) w_state_nxt[i] = ST_ON;
          end
        end
        ST_ON: begin
          if (!r_pattern_q[i]) w_state_nxt[i] = ST_FALLING;
        end
        ST_FALLING: begin
          if (r_pattern_q[i]) begin
            w_state_nxt[i] = ST_RISING;
          end else if (r_bright[i] == '0) begin
            w_state_nxt[i] = ST_OFF;
          end else if (w_tick) begin
            w_bright_nxt[i] = r_bright[i] - ONE;
            if (r_bright[i] == ONE) w_state_nxt[i] = ST_OFF;
          end
        end
        default: begin
          w_state_nxt[i]  = ST_OFF;
          w_bright_nxt[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_moving = '0;
    for (int i = 0; i < NLEDS; i++) begin
      w_moving[i] = (r_state[i] == ST_RISING) || (r_state[i] == ST_FALLING);
    end
  end

`ifdef LED_FADER_GAMMA_EN
  // Square-law duty, truncated back to PWM_BITS, registered for timing.
  logic [2*PWM_BITS-1:0] w_sq    [NLEDS];
  logic [PWM_BITS-1:0]   r_duty  [NLEDS];

  always_comb begin
    for (int i = 0; i < NLEDS; i++) begin
      w_sq[i] = {{PWM_BITS{1'b0}}, r_bright[i]} * {{PWM_BITS{1'b0}}, r_bright[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NLEDS; i++) r_duty[i] <= '0;
    end else begin
      for (int i = 0; i < NLEDS; i++) r_duty[i] <= PWM_BITS'(w_sq[i] >> PWM_BITS);
    end
  end

  always_comb begin
    for (int i = 0; i < NLEDS; i++) w_duty[i] = r_duty[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NLEDS; i++) w_duty[i] = r_bright[i];
  end
`endif

  // Strict '>' means duty 0 is always dark and duty BMAX has one dark cycle
  // per PWM period.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds <= '0;
      busy <= 1'b0;
    end else begin
      for (int i = 0; i < NLEDS; i++) leds[i] <= (w_duty[i] > r_pwm_cnt);
      busy <= |w_moving;
    end
  end

  always_comb begin
    for (int i = 0; i < NLEDS; i++) begin
      o_dbg_state[2*i +: 2]                = r_state[i];
      o_dbg_bright[i*PWM_BITS +: PWM_BITS] = r_bright[i];
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// ----------------------------------------------------------------------------
// tb_led_fader
// Bench for led_fader with NLEDS=8, PWM_BITS=4, STEP_LOG2=2. A behavioural
// model tracks, per channel, the last target direction seen, whether the
// channel is still moving, and its brightness; it derives leds/busy from that.
// A compare process checks leds, busy and brightness every cycle; directed
// scenarios add hand-computed literal expectations, followed by random traffic.
// ----------------------------------------------------------------------------
module tb_led_fader;

  localparam int NL      = 8;
  localparam int PB      = 4;
  localparam int SL      = 2;
  localparam int BMAX    = (1 << PB) - 1;
  localparam int PRE_MAX = (1 << SL) - 1;

  // ---------------- clock / reset block ----------------
  logic            clk = 1'b0;
  logic            resetn;
  logic [NL-1:0]   pattern;
  logic [NL-1:0]   leds;
  logic            busy;
  logic [2*NL-1:0] dbg_state;
  logic [NL*PB-1:0] dbg_bright;

  always #5 clk = ~clk;

  led_fader #(.NLEDS(NL), .PWM_BITS(PB), .STEP_LOG2(SL)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pattern      (pattern),
    .leds         (leds),
    .busy         (busy),
    .o_dbg_state  (dbg_state),
    .o_dbg_bright (dbg_bright)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int get_b(input int ch);
    return int'(dbg_bright[ch*PB +: PB]);
  endfunction

  // ---------------- behavioural model ----------------
  bit [NL-1:0] m_pq;
  bit          m_d   [NL];   // direction the channel last committed to
  bit          m_mov [NL];   // still ramping toward that direction's end
  int          m_b   [NL];
  int          m_dq  [NL];   // registered gamma duty (gamma build only)
  int          m_pwm, m_pre;
  bit [NL-1:0] m_leds;
  bit          m_busy;

  function automatic int gamma_of(input int b);
    return (b * b) >> PB;
  endfunction

  initial begin
    m_pq = '0; m_pwm = 0; m_pre = 0; m_leds = '0; m_busy = 0;
    for (int i = 0; i < NL; i++) begin
      m_d[i] = 0; m_mov[i] = 0; m_b[i] = 0; m_dq[i] = 0;
    end
  end

  always @(posedge clk) begin
    bit [NL-1:0] nl;
    bit nb, tk;
    int dt, endv;
    if (!resetn) begin
      m_pq = '0; m_pwm = 0; m_pre = 0; m_leds = '0; m_busy = 0;
      for (int i = 0; i < NL; i++) begin
        m_d[i] = 0; m_mov[i] = 0; m_b[i] = 0; m_dq[i] = 0;
      end
    end else begin
      tk = (m_pre == PRE_MAX);
      nb = 0;
      nl = '0;
      for (int i = 0; i < NL; i++) begin
`ifdef LED_FADER_GAMMA_EN
        dt = m_dq[i];
`else
        dt = m_b[i];
`endif
        nl[i] = (dt > m_pwm);
        nb = nb | m_mov[i];
      end
      for (int i = 0; i < NL; i++) m_dq[i] = gamma_of(m_b[i]);
      for (int i = 0; i < NL; i++) begin
        endv = m_d[i] ? BMAX : 0;
        if (m_pq[i] != m_d[i]) begin
          m_d[i]   = m_pq[i];
          m_mov[i] = 1;
        end else if (m_mov[i]) begin
          if (m_b[i] == endv) m_mov[i] = 0;
          else if (tk) begin
            m_b[i] = m_b[i] + (m_d[i] ? 1 : -1);
            if (m_b[i] == endv) m_mov[i] = 0;
          end
        end
      end
      m_leds = nl;
      m_busy = nb;
      m_pq   = pattern;
      m_pwm  = (m_pwm + 1) % (BMAX + 1);
      m_pre  = (m_pre + 1) % (PRE_MAX + 1);
    end
  end

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    logic [NL*PB-1:0] mbv;
    if (chk_en) begin
      for (int i = 0; i < NL; i++) mbv[i*PB +: PB] = PB'(m_b[i]);
      check("leds", 64'(leds), 64'(m_leds));
      check("busy", 64'(busy), 64'(m_busy));
      check("bright", 64'(dbg_bright), 64'(mbv));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_b(input int ch, input int val, input int limit, output int cycles);
    cycles = 0;
    while (get_b(ch) != val && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    if (get_b(ch) != val) fail_now($sformatf("wait_b ch%0d=%0d", ch, val));
  endtask

  task automatic wait_idle(input int limit);
    int c;
    c = 0;
    repeat (3) @(negedge clk);
    while (busy && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (busy) fail_now("wait_idle");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int cyc, c2, cnt, mx, exp_full, exp_mid;
    logic others;

`ifdef LED_FADER_GAMMA_EN
    exp_full = 14;  // (15*15)>>4
    exp_mid  = 1;   // (5*5)>>4
`else
    exp_full = 15;
    exp_mid  = 5;
`endif

    // Reset held with all targets on: outputs stay dark and idle.
    resetn  = 1'b0;
    pattern = 8'hFF;
    @(posedge clk);
    chk_en = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_leds", 64'(leds), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
    end
    resetn  = 1'b1;
    pattern = 8'h00;
    repeat (8) @(negedge clk);

    // Single rise on channel 0.
    pattern = 8'h01;
    cyc = 0;
    while (!busy && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_latency", 64'(cyc), 64'd3);
    wait_b(0, BMAX, 100, c2);
    check("ramp_time_in_window", 64'((cyc + c2 >= 56) && (cyc + c2 <= 64)), 64'd1);
    check("busy_at_on", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_after_on", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    cnt = 0;
    others = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cnt += int'(leds[0]);
      others = others | (|leds[7:1]);
    end
    check("led0_on_cycles", 64'(cnt), 64'(exp_full));
    check("leds_7_1_dark", 64'(others), 64'd0);

    // Mid-ramp reversal on channel 0.
    pattern = 8'h00;
    wait_b(0, 0, 120, c2);
    wait_idle(20);
    pattern = 8'h01;
    wait_b(0, 6, 100, c2);
    pattern = 8'h00;
    mx = get_b(0);
    c2 = 0;
    while (get_b(0) != 0 && c2 < 100) begin
      @(negedge clk);
      c2++;
      if (get_b(0) > mx) mx = get_b(0);
    end
    check("rev_peak", 64'((mx == 6) || (mx == 7)), 64'd1);
    repeat (6) @(negedge clk);
    check("rev_no_underflow", 64'(get_b(0)), 64'd0);
    check("rev_busy_clear", 64'(busy), 64'd0);

    // Brightness parked at 5 on channel 3 by reversing every cycle.
    wait_idle(20);
    pattern = 8'h08;
    wait_b(3, 5, 100, c2);
    pattern = 8'h00;
    cnt = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      pattern = pattern ^ 8'h08;
      if (k >= 4 && k < 20) cnt += int'(leds[3]);
    end
    check("parked_b3", 64'(get_b(3)), 64'd5);
    check("duty_b5_on_cycles", 64'(cnt), 64'(exp_mid));
    pattern = 8'h00;
    wait_idle(120);

    // Reset in the middle of an all-channel fade.
    pattern = 8'hFF;
    wait_b(0, 9, 200, c2);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midfade_bright", 64'(dbg_bright), 64'd0);
    check("midfade_leds", 64'(leds), 64'd0);
    check("midfade_busy", 64'(busy), 64'd0);
    wait_b(7, 1, 40, c2);
    check("restart_b7", 64'(get_b(7)), 64'd1);

    // Random traffic, including 1-cycle pulses and occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      int hold;
      pattern = NL'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
      repeat (hold) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
